uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//   Byte FIFO and launch sequencer directly upstream of UART_TX.
//   - Host side pushes bytes with a one-cycle strobe.
//   - The block replays them to UART_TX one at a time, using the i_TX_DV/i_TX_Byte
//     handshake, and waits for o_TX_Done before launching the next byte.
//   - Lets the host burst-write a message without tracking the serial line.
// PARAMETERS
//   DEPTH_LOG2  4  log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 = 16 entries
// PORTS
//   i_Clock     in   1             system clock; all logic on rising edge
//   i_Reset     in   1             synchronous reset, active-high
//   i_Wr_DV     in   1             host write strobe, one byte per cycle
//   i_Wr_Byte   in   8             host write data
//   o_Full      out  1             FIFO holds DEPTH entries
//   o_Empty     out  1             FIFO holds 0 entries
//   o_Overflow  out  1             sticky: a write was dropped; cleared only by i_Reset
//   o_Busy      out  1             FSM not IDLE, or FIFO not empty
//   o_TX_DV     out  1             to UART_TX i_TX_DV; one-cycle launch pulse
//   o_TX_Byte   out  8             to UART_TX i_TX_Byte; registered, held until next launch
//   i_TX_Done   in   1             from UART_TX o_TX_Done
//   o_Count     out  DEPTH_LOG2+1  occupancy; only when UART_TXF_COUNT_EN is defined
// BEHAVIOUR
//   Reset (sync, wins over all other inputs):
//   - Pointers = 0 and FSM = IDLE.
//   - o_Empty = 1.
//   - o_Full, o_Overflow, o_Busy, o_TX_DV = 0; o_TX_Byte = 8'h00; o_Count = 0.
//   FIFO:
//   - Read and write pointers are DEPTH_LOG2+1 bits and wrap modulo 2*DEPTH.
//   - Empty when the pointers are equal.
//   - Full when the MSBs differ and the remaining bits are equal.
//   - Flags are registered and valid the cycle after the causing event.
//   - Write is accepted when i_Wr_DV=1 and o_Full=0 (registered value).
//   - Write while o_Full=1 is dropped and sets o_Overflow next cycle.
//     This holds even if a pop happens in the same cycle.
//   - A pop happens only in LAUNCH. Write and pop in the same cycle change
//     occupancy by 0 and the data stays correct.
//   FSM (IDLE, LAUNCH, GUARD, WAIT_DONE):
//   - IDLE: if o_Empty=0, go to LAUNCH.
//   - LAUNCH: one cycle; o_TX_DV=1, o_TX_Byte<=head entry, read pointer+1; go to GUARD.
//   - GUARD: one cycle; i_TX_Done ignored (stale Done from UART_TX idle); go to WAIT_DONE.
//   - WAIT_DONE: stay until i_TX_Done=1, then go to IDLE.
//   - No timeout.
//   Latency and rate:
//   - First write into an empty, idle block: o_TX_DV rises 2 cycles after the i_Wr_DV cycle.
//   - Minimum spacing between consecutive o_TX_DV pulses: Done cycle + 2.
//   - o_TX_DV is never high outside LAUNCH.
//   Reset during WAIT_DONE:
//   - FIFO is flushed and the FSM returns to IDLE.
//   - The in-flight UART_TX byte completes on the line; its i_TX_Done is ignored in IDLE.
// CONFIGURATION
//   UART_TXF_COUNT_EN defined:
//   - o_Count port exists = write pointer - read pointer, range 0..DEPTH.
//   - Registered; updates together with the flags.
//   UART_TXF_COUNT_EN undefined:
//   - Port and logic are absent; all other behaviour is identical.
// TESTING
//   Bench: 25 MHz clock; UART_TX and UART_RX with CLKS_PER_BIT=217; RX line held at 1
//   when TX is not active.
//   1 Single write 8'h3F -> RX o_RX_Byte=8'h3F; exactly one o_TX_DV pulse;
//     o_Empty=1 and o_Busy=0 after Done.
//   2 Back-to-back writes 8'h11,8'h22,8'h33,8'h44 -> RX bytes received in that order;
//     4 o_TX_DV pulses, each after the previous i_TX_Done.
//   3 Stub TX (i_TX_Done tied 0); 18 writes 8'h00..8'h11 on consecutive cycles
//     -> 8'h00 launched; o_Full=1; 8'h11 dropped; o_Overflow=1; o_Count=16.
//   4 Full FIFO; write 8'hAA in the same cycle as the LAUNCH pop
//     -> 8'hAA dropped, o_Overflow=1, o_Count=15.
//   5 i_Reset pulse mid-WAIT_DONE with 3 entries queued
//     -> o_Empty=1, o_Busy=0, o_Overflow=0; no further o_TX_DV pulses.
//   6 Fill 16 entries, drain all, refill 16 (pointer wrap) -> 32 bytes received in
//     order, no o_Overflow; o_Count returns to 0.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Host-write, status and UART_TX launch signals of uart_tx_fifo.
// o_Count exists only when UART_TXF_COUNT_EN is defined.
interface uart_tx_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  i_Wr_DV;
   logic [7:0]            i_Wr_Byte;
   logic                  o_Full;
   logic                  o_Empty;
   logic                  o_Overflow;
   logic                  o_Busy;
   logic                  o_TX_DV;
   logic [7:0]            o_TX_Byte;
   logic                  i_TX_Done;
`ifdef UART_TXF_COUNT_EN
   logic [DEPTH_LOG2:0]   o_Count;
`endif

   modport slave (
      input  i_Wr_DV, i_Wr_Byte, i_TX_Done,
      output o_Full, o_Empty, o_Overflow, o_Busy, o_TX_DV, o_TX_Byte
`ifdef UART_TXF_COUNT_EN
      , output o_Count
`endif
   );

   modport master (
      output i_Wr_DV, i_Wr_Byte, i_TX_Done,
      input  o_Full, o_Empty, o_Overflow, o_Busy, o_TX_DV, o_TX_Byte
`ifdef UART_TXF_COUNT_EN
      , input o_Count
`endif
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding UART_TX one byte per o_TX_Done.
// Define UART_TXF_COUNT_EN to add the registered occupancy output o_Count.
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic          i_Clock,
   input  logic          i_Reset,
   uart_tx_fifo_if.slave bus
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   typedef logic [DEPTH_LOG2:0] ptr_t;
   typedef enum logic [1:0] {IDLE, LAUNCH, GUARD, WAIT_DONE} state_e;

   state_e     state_q, state_d;
   ptr_t       wr_ptr_q, wr_ptr_d;
   ptr_t       rd_ptr_q, rd_ptr_d;
   logic       full_q, full_d;
   logic       empty_q, empty_d;
   logic       overflow_q, overflow_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic [7:0] mem_q [DEPTH];
   logic       wr_en;
   logic       pop;

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (!empty_q) state_d = LAUNCH;
         LAUNCH:    state_d = GUARD;
         GUARD:     state_d = WAIT_DONE;
         WAIT_DONE: if (bus.i_TX_Done) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_en      = bus.i_Wr_DV && !full_q;
      pop        = (state_q == LAUNCH);
      wr_ptr_d   = wr_ptr_q + ptr_t'(wr_en);
      rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
      empty_d    = (wr_ptr_d == rd_ptr_d);
      full_d     = (wr_ptr_d[DEPTH_LOG2] != rd_ptr_d[DEPTH_LOG2]) &&
                   (wr_ptr_d[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]);
      overflow_d = overflow_q || (bus.i_Wr_DV && full_q);
      // Head byte is captured on entry to LAUNCH so it is stable while o_TX_DV is high.
      tx_byte_d  = tx_byte_q;
      if (state_q == IDLE && !empty_q) tx_byte_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         tx_byte_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         tx_byte_q  <= tx_byte_d;
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge i_Clock) begin
      if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.i_Wr_Byte;
   end

`ifdef UART_TXF_COUNT_EN
   ptr_t count_q;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) count_q <= '0;
      else         count_q <= wr_ptr_d - rd_ptr_d;
   end

   assign bus.o_Count = count_q;
`endif

   assign bus.o_Full     = full_q;
   assign bus.o_Empty    = empty_q;
   assign bus.o_Overflow = overflow_q;
   assign bus.o_Busy     = (state_q != IDLE) || !empty_q;
   assign bus.o_TX_DV    = (state_q == LAUNCH);
   assign bus.o_TX_Byte  = tx_byte_q;
endmodule
